image_stream_reader: RTL

- Reader for the processed-image memory that the processor core fills.
- On a start pulse it walks a contiguous pixel range and streams each 8-bit pixel out on a valid/ready byte interface, with out_last on the final pixel.
- Feeds the display/UART export path.
- Owns the read port of the processed-image memory; the memory's read is synchronous with 1-cycle latency.

---
 rtl/image_stream_pkg.sv | 15 +
 rtl/image_stream_reader_stream_fifo2.sv | 70 +++++++
 rtl/image_stream_reader.sv | 126 ++++++++++++
 3 files changed

// File: rtl/image_stream_pkg.sv
// Shared types and constants for the processed-image stream reader.
package image_stream_pkg;

  localparam int PIX_W      = 8;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_CNT_W  = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/image_stream_reader_stream_fifo2.sv
// Two-entry register FIFO; entry 0 is always the head.
module image_stream_reader_stream_fifo2
  import image_stream_pkg::*;
#(
  parameter int W = PIX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok;

  assign pop_ok = pop && (count_q != 2'd0);

  // Next entry contents and occupancy for push, pop, or both in one cycle.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    case ({push, pop_ok})
      2'b10: begin
        if (count_q == 2'd0) begin
          ent0_d  = din;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          ent1_d  = din;
          count_d = 2'd2;
        end
      end
      2'b01: begin
        ent0_d  = ent1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          ent0_d = din;
        end else begin
          ent0_d = ent1_q;
          ent1_d = din;
        end
      end
      default: ;
    endcase
  end

  // Storage registers; reset leaves the FIFO empty with zeroed entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = ent0_q;

endmodule

// File: rtl/image_stream_reader.sv
// Streams a contiguous pixel range from the processed-image memory onto a
// valid/ready byte interface. The memory read is synchronous (1-cycle latency).
//
// mem_addr_q always holds the next address to read (base + issued). A read is
// issued in the cycle the address is on the bus, so the memory samples it at
// the closing edge and its data is pushed one edge later. Counting the pop of
// the current cycle in the occupancy lets the stream run at one beat per cycle
// while FIFO + in-flight never exceeds the two FIFO entries.
module image_stream_reader
  import image_stream_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = PIX_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  pix_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  beats_q, beats_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic [2:0]        occ;
  logic              pop;
  logic              issue;
  logic              accept;

  image_stream_reader_stream_fifo2 #(.W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (inflight_q),
    .din   (mem_rd),
    .pop   (pop),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign pop    = out_valid && out_ready;
  assign accept = (state_q == ST_IDLE) && start;
  assign occ    = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue  = (state_q == ST_READ) && (issued_q < cnt_q) && (occ < 3'd2);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (pix_count == '0) ? ST_DONE : ST_READ;
      ST_READ:  if (issue && (issued_q + CNT_W'(1) == cnt_q)) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && out_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state, FIFO occupancy and the beat counter.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    out_valid = (fifo_count != 2'd0);
    out_data  = fifo_head;
    out_last  = out_valid && (beats_q == cnt_q - CNT_W'(1));
    mem_addr  = mem_addr_q;
  end

  // Counters, latched transfer parameters and read address update.
  always_comb begin
    cnt_d      = cnt_q;
    issued_d   = issued_q;
    beats_d    = beats_q;
    mem_addr_d = mem_addr_q;
    inflight_d = issue;
    if (accept) begin
      cnt_d      = pix_count;
      issued_d   = '0;
      beats_d    = '0;
      mem_addr_d = base_addr;
    end else begin
      if (issue) begin
        issued_d   = issued_q + CNT_W'(1);
        mem_addr_d = mem_addr_q + ADDR_W'(1);
      end
      if (pop) beats_d = beats_q + CNT_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      issued_q   <= '0;
      beats_q    <= '0;
      inflight_q <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      issued_q   <= issued_d;
      beats_q    <= beats_d;
      inflight_q <= inflight_d;
      mem_addr_q <= mem_addr_d;
    end
  end

endmodule
